// File: rtl/bb_microseq_datapath.sv
// Parametrised micro-sequenced datapath: register file with constant r0, ALU with
// {N,Z,C,V} flags, program counter, and a registered display read-back port.
// Each micro-instruction is accepted over valid/ready and runs IDLE -> EXEC -> WB.
module bb_microseq_datapath #(
  parameter int                       DATAWIDTH_BUS           = 32,
  parameter int                       NUM_REGS                = 8,
  parameter int                       DATAWIDTH_MUX_SELECTION = 3,
  parameter int                       DATAWIDTH_ALU_SELECTION = 4,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0    = '0,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGGEN_INIT_0      = '0,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGPC_INIT         = 'h800,
  parameter int                       PC_INCREMENT            = 4
) (
  input  logic                               BB_MICROSEQ_CLOCK_50,
  input  logic                               BB_MICROSEQ_Reset_InLow,
  input  logic                               BB_MICROSEQ_Valid_In,
  output logic                               BB_MICROSEQ_Ready_Out,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] BB_MICROSEQ_Op_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0] BB_MICROSEQ_SelA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0] BB_MICROSEQ_SelB_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0] BB_MICROSEQ_SelC_In,
  input  logic                               BB_MICROSEQ_UseImm_In,
  input  logic [DATAWIDTH_BUS-1:0]           BB_MICROSEQ_Imm_In,
  output logic                               BB_MICROSEQ_Done_Out,
  output logic [3:0]                         BB_MICROSEQ_Flags_Out,
  output logic [DATAWIDTH_BUS-1:0]           BB_MICROSEQ_PC_Out,
  input  logic [DATAWIDTH_MUX_SELECTION:0]   BB_MICROSEQ_DisplaySel_In,
  output logic [DATAWIDTH_BUS-1:0]           BB_MICROSEQ_DataBUSDisplay_Out
);

  localparam int W   = DATAWIDTH_BUS;
  localparam int SW  = DATAWIDTH_MUX_SELECTION;
  localparam int OW  = DATAWIDTH_ALU_SELECTION;
  localparam int SHW = $clog2(DATAWIDTH_BUS);

  localparam logic [W-1:0] PC_STEP = W'(PC_INCREMENT);

  localparam logic [OW-1:0] OP_ADD   = OW'(0);
  localparam logic [OW-1:0] OP_SUB   = OW'(1);
  localparam logic [OW-1:0] OP_AND   = OW'(2);
  localparam logic [OW-1:0] OP_OR    = OW'(3);
  localparam logic [OW-1:0] OP_XOR   = OW'(4);
  localparam logic [OW-1:0] OP_NOT   = OW'(5);
  localparam logic [OW-1:0] OP_PASSB = OW'(6);
  localparam logic [OW-1:0] OP_SLL   = OW'(7);
  localparam logic [OW-1:0] OP_SRL   = OW'(8);
  localparam logic [OW-1:0] OP_SRA   = OW'(9);
  localparam logic [OW-1:0] OP_MOVPC = OW'(10);
  localparam logic [OW-1:0] OP_JMP   = OW'(11);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_e;

  // Aliases for readability
  logic clk, rst_n;
  assign clk   = BB_MICROSEQ_CLOCK_50;
  assign rst_n = BB_MICROSEQ_Reset_InLow;

  state_e         state_q, state_d;
  logic           accept;

  logic [OW-1:0]  op_q;
  logic [SW-1:0]  sela_q, selb_q, selc_q;
  logic           useimm_q;
  logic [W-1:0]   imm_q;

  logic [W-1:0]   regs_q [1:NUM_REGS-1];
  logic [W-1:0]   rf_view [0:NUM_REGS-1];
  logic [W-1:0]   pc_q;
  logic [3:0]     flags_q;

  logic [W-1:0]   op_a, op_b;
  logic [SHW-1:0] shamt;
  logic [W:0]     sum_ext, dif_ext;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic [W-1:0]   res_q;
  logic [3:0]     nflags_q;

  logic           wr_en, flags_en, is_jmp;
  logic [W-1:0]   disp_d, disp_q;

  assign accept = (state_q == ST_IDLE) && BB_MICROSEQ_Valid_In;

  // FSM state register
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: state_d = BB_MICROSEQ_Valid_In ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only while idle, done for the single writeback cycle
  always_comb begin
    BB_MICROSEQ_Ready_Out = (state_q == ST_IDLE);
    BB_MICROSEQ_Done_Out  = (state_q == ST_WB);
  end

  // Instruction field capture at acceptance; fields are ignored at any other time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sela_q   <= '0;
      selb_q   <= '0;
      selc_q   <= '0;
      useimm_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= BB_MICROSEQ_Op_In;
      sela_q   <= BB_MICROSEQ_SelA_In;
      selb_q   <= BB_MICROSEQ_SelB_In;
      selc_q   <= BB_MICROSEQ_SelC_In;
      useimm_q <= BB_MICROSEQ_UseImm_In;
      imm_q    <= BB_MICROSEQ_Imm_In;
    end
  end

  // Read view of the register file with r0 pinned to its constant
  always_comb begin
    rf_view[0] = DATA_REGFIXED_INIT_0;
    for (int i = 1; i < NUM_REGS; i++) rf_view[i] = regs_q[i];
  end

  // Operand selection and ALU
  always_comb begin
    op_a    = rf_view[sela_q];
    op_b    = useimm_q ? imm_q : rf_view[selb_q];
    shamt   = op_b[SHW-1:0];
    sum_ext = {1'b0, op_a} + {1'b0, op_b};
    dif_ext = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (op_a[W-1] == op_b[W-1]) && (sum_ext[W-1] != op_a[W-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[W-1:0];
        alu_c   = dif_ext[W];
        alu_v   = (op_a[W-1] != op_b[W-1]) && (dif_ext[W-1] != op_a[W-1]);
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOT:   alu_res = ~op_a;
      OP_PASSB: alu_res = op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $signed(op_a) >>> shamt;
      OP_MOVPC: alu_res = pc_q;
      OP_JMP:   alu_res = op_a;
      default:  alu_res = '0;
    endcase
  end

  // EXEC stage: register the result and the candidate flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      nflags_q <= '0;
    end else if (state_q == ST_EXEC) begin
      res_q    <= alu_res;
      nflags_q <= {alu_res[W-1], (alu_res == '0), alu_c, alu_v};
    end
  end

  // Writeback qualifiers derived from the captured opcode
  always_comb begin
    wr_en    = (op_q <= OP_MOVPC);
    flags_en = (op_q <= OP_SRA);
    is_jmp   = (op_q == OP_JMP);
  end

  // Register file writeback; at most one register per WB, r0 has no storage
  // NOTE: the file is small and must come up at a known value, so it is reset like any flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= DATA_REGGEN_INIT_0;
    end else if (state_q == ST_WB && wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (selc_q == SW'(i)) regs_q[i] <= res_q;
      end
    end
  end

  // PC and flags update at writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= DATA_REGPC_INIT;
      flags_q <= '0;
    end else if (state_q == ST_WB) begin
      pc_q <= is_jmp ? res_q : pc_q + PC_STEP;
      if (flags_en) flags_q <= nflags_q;
    end
  end

  // Display source select: register, PC, or zero-extended flags
  always_comb begin
    disp_d = rf_view[BB_MICROSEQ_DisplaySel_In[SW-1:0]];
    if (BB_MICROSEQ_DisplaySel_In[SW]) begin
      disp_d = BB_MICROSEQ_DisplaySel_In[0] ? {{(W-4){1'b0}}, flags_q} : pc_q;
    end
  end

  // Registered display port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= DATA_REGFIXED_INIT_0;
    else        disp_q <= disp_d;
  end

  assign BB_MICROSEQ_Flags_Out          = flags_q;
  assign BB_MICROSEQ_PC_Out             = pc_q;
  assign BB_MICROSEQ_DataBUSDisplay_Out = disp_q;

endmodule

// File: tb/tb_bb_microseq_datapath.sv
// Directed bench for bb_microseq_datapath: hand-computed expected values for
// reset, handshake timing, every ALU op class, flags, r0, JMP/MOVPC/NOP and display.
module tb_bb_microseq_datapath;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [3:0]  op;
  logic [2:0]  sa, sb, sc;
  logic        ui;
  logic [31:0] imm;
  logic        done;
  logic [3:0]  flags;
  logic [31:0] pc;
  logic [3:0]  dsel;
  logic [31:0] disp;

  int nvec = 0;
  int nerr = 0;

  bb_microseq_datapath dut (
    .BB_MICROSEQ_CLOCK_50           (clk),
    .BB_MICROSEQ_Reset_InLow        (rst_n),
    .BB_MICROSEQ_Valid_In           (valid),
    .BB_MICROSEQ_Ready_Out          (ready),
    .BB_MICROSEQ_Op_In              (op),
    .BB_MICROSEQ_SelA_In            (sa),
    .BB_MICROSEQ_SelB_In            (sb),
    .BB_MICROSEQ_SelC_In            (sc),
    .BB_MICROSEQ_UseImm_In          (ui),
    .BB_MICROSEQ_Imm_In             (imm),
    .BB_MICROSEQ_Done_Out           (done),
    .BB_MICROSEQ_Flags_Out          (flags),
    .BB_MICROSEQ_PC_Out             (pc),
    .BB_MICROSEQ_DisplaySel_In      (dsel),
    .BB_MICROSEQ_DataBUSDisplay_Out (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check handshake timing, flags and PC after writeback.
  task automatic issue(input string tag, input logic [3:0] o, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] c, input logic u,
                       input logic [31:0] im, input logic [3:0] exp_flags,
                       input logic [31:0] exp_pc);
    @(negedge clk);
    op = o; sa = a; sb = b; sc = c; ui = u; imm = im; valid = 1'b1;
    check({tag, " ready@accept"}, ready, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    op = ~o; sa = ~a; sb = ~b; sc = ~c; ui = ~u; imm = ~im;
    check({tag, " done@exec"}, done, 1'b0);
    check({tag, " ready@exec"}, ready, 1'b0);
    @(posedge clk); #1;
    check({tag, " done@wb"}, done, 1'b1);
    check({tag, " ready@wb"}, ready, 1'b0);
    @(posedge clk); #1;
    check({tag, " done@idle"}, done, 1'b0);
    check({tag, " ready@idle"}, ready, 1'b1);
    check({tag, " flags"}, flags, exp_flags);
    check({tag, " pc"}, pc, exp_pc);
  endtask

  // Select a display source and check the registered value one edge later.
  task automatic rd(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    @(negedge clk);
    dsel = sel;
    @(negedge clk);
    check(tag, disp, exp);
  endtask

  initial begin
    logic [8:0] rdy_vec;
    int         done_cnt;

    rst_n = 1'b1; valid = 1'b0; op = '0; sa = '0; sb = '0; sc = '0;
    ui = 1'b0; imm = '0; dsel = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset ready", ready, 1'b1);
    check("reset done", done, 1'b0);
    check("reset flags", flags, 4'h0);
    check("reset pc", pc, 32'h800);
    check("reset display", disp, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    op = 4'd0; sa = 3'd0; sb = 3'd0; sc = 3'd3; ui = 1'b1; imm = 32'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("abort ready@exec", ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort ready", ready, 1'b1);
    check("abort done", done, 1'b0);
    check("abort pc", pc, 32'h800);
    check("abort flags", flags, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort no done 1", done, 1'b0);
    @(posedge clk); #1;
    check("abort no done 2", done, 1'b0);
    rd("abort r3", 4'd3, 32'h0);

    // Basic arithmetic
    issue("add r1=0+5",   4'd0, 3'd0, 3'd0, 3'd1, 1'b1, 32'd5, 4'b0000, 32'h804);
    rd("r1=5", 4'd1, 32'd5);
    issue("sub r2=r1-5",  4'd1, 3'd1, 3'd0, 3'd2, 1'b1, 32'd5, 4'b0110, 32'h808);
    rd("r2=0", 4'd2, 32'd0);
    issue("pass r1",      4'd6, 3'd0, 3'd0, 3'd1, 1'b1, 32'h7FFF_FFFF, 4'b0000, 32'h80C);
    issue("add ovf",      4'd0, 3'd1, 3'd0, 3'd1, 1'b1, 32'd1, 4'b1001, 32'h810);
    rd("r1=80000000", 4'd1, 32'h8000_0000);
    issue("pass r4",      4'd6, 3'd0, 3'd0, 3'd4, 1'b1, 32'hFFFF_FFFF, 4'b1000, 32'h814);
    issue("add carry",    4'd0, 3'd4, 3'd0, 3'd5, 1'b1, 32'd1, 4'b0110, 32'h818);
    rd("r5=0", 4'd5, 32'h0);
    issue("add r4+r4",    4'd0, 3'd4, 3'd4, 3'd6, 1'b0, 32'h0, 4'b1010, 32'h81C);
    rd("r6=fffffffe", 4'd6, 32'hFFFF_FFFE);

    // Valid held high for three instructions: accepts only at edges 0, 3, 6
    @(negedge clk);
    op = 4'd0; sa = 3'd7; sb = 3'd0; sc = 3'd7; ui = 1'b1; imm = 32'd1; valid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      rdy_vec[i] = ready;
      done_cnt += int'(done);
      @(posedge clk);
      @(negedge clk);
    end
    valid = 1'b0;
    check("stream accept pattern", rdy_vec, 9'b001_001_001);
    check("stream done count", done_cnt, 3);
    check("stream pc", pc, 32'h828);
    rd("stream r7=3", 4'd7, 32'd3);

    // r0 writes are dropped; flags and PC still update
    issue("pass r0",      4'd6, 3'd0, 3'd0, 3'd0, 1'b1, 32'h0000_DEAD, 4'b0000, 32'h82C);
    rd("r0 after pass", 4'd0, 32'h0);
    issue("sub r0",       4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 32'h0000_DEAD, 4'b1000, 32'h830);
    rd("r0 after sub", 4'd0, 32'h0);

    // JMP, MOVPC, NOP
    issue("pass r1=1000", 4'd6, 3'd0, 3'd0, 3'd1, 1'b1, 32'h1000, 4'b0000, 32'h834);
    issue("sub r3=0-1",   4'd1, 3'd0, 3'd0, 3'd3, 1'b1, 32'd1, 4'b1000, 32'h838);
    issue("jmp r1",       4'd11, 3'd1, 3'd0, 3'd3, 1'b1, 32'h5555, 4'b1000, 32'h1000);
    rd("jmp r3 kept", 4'd3, 32'hFFFF_FFFF);
    issue("movpc r4",     4'd10, 3'd0, 3'd0, 3'd4, 1'b1, 32'h0, 4'b1000, 32'h1004);
    rd("r4=pc", 4'd4, 32'h1000);
    issue("nop",          4'd12, 3'd0, 3'd0, 3'd6, 1'b1, 32'h1234, 4'b1000, 32'h1008);
    rd("nop r6 kept", 4'd6, 32'hFFFF_FFFE);

    // Shifts
    issue("pass r1=msb",  4'd6, 3'd0, 3'd0, 3'd1, 1'b1, 32'h8000_0000, 4'b1000, 32'h100C);
    issue("sra",          4'd9, 3'd1, 3'd0, 3'd2, 1'b1, 32'd4, 4'b1000, 32'h1010);
    rd("r2 sra", 4'd2, 32'hF800_0000);
    issue("srl",          4'd8, 3'd1, 3'd0, 3'd3, 1'b1, 32'd4, 4'b0000, 32'h1014);
    rd("r3 srl", 4'd3, 32'h0800_0000);
    issue("sub set c",    4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 32'd0, 4'b0110, 32'h1018);
    issue("sll by 0",     4'd7, 3'd1, 3'd0, 3'd6, 1'b1, 32'd0, 4'b1000, 32'h101C);
    rd("r6 sll0", 4'd6, 32'h8000_0000);
    issue("sll by 0x21",  4'd7, 3'd1, 3'd0, 3'd7, 1'b1, 32'h21, 4'b0100, 32'h1020);
    rd("r7 sll33", 4'd7, 32'h0);

    // Logic ops
    issue("xor r3^r2",    4'd4, 3'd3, 3'd2, 3'd5, 1'b0, 32'h0, 4'b1000, 32'h1024);
    rd("r5 xor", 4'd5, 32'hF000_0000);
    issue("not r3",       4'd5, 3'd3, 3'd0, 3'd6, 1'b1, 32'h0, 4'b1000, 32'h1028);
    rd("r6 not", 4'd6, 32'hF7FF_FFFF);
    rd("display flags", 4'b1001, 32'h8);
    issue("and imm",      4'd2, 3'd2, 3'd0, 3'd7, 1'b1, 32'h0F00_0000, 4'b0000, 32'h102C);
    issue("or imm",       4'd3, 3'd7, 3'd0, 3'd7, 1'b1, 32'd1, 4'b0000, 32'h1030);
    rd("r7 or", 4'd7, 32'h0800_0001);

    // Same register as both sources and destination
    issue("add r3+r3",    4'd0, 3'd3, 3'd3, 3'd3, 1'b0, 32'h0, 4'b0000, 32'h1034);
    rd("r3 doubled", 4'd3, 32'h1000_0000);
    rd("display pc", 4'b1000, 32'h1034);

    // PC wraps around
    issue("pass r1=top",  4'd6, 3'd0, 3'd0, 3'd1, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'h1038);
    issue("jmp top",      4'd11, 3'd1, 3'd0, 3'd2, 1'b1, 32'h0, 4'b1000, 32'hFFFF_FFFC);
    issue("nop wrap",     4'd15, 3'd0, 3'd0, 3'd2, 1'b1, 32'h0, 4'b1000, 32'h0);
    rd("display pc wrap", 4'b1000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
